// File: rtl/non_max_suppression.sv
// Canny non-maximum suppression over a raster stream, using two line buffers and a 3x3 window.
// Each pixel's output is registered one cycle after the input that completes its window.
module non_max_suppression #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] grad_mag,
    input  logic [1:0] grad_dir,
    input  logic       pixel_in_valid,
    output logic [7:0] nms_mag,
    output logic       nms_valid,
    output logic       frame_done,
    output logic       overrun_err
);
    // state | meaning
    // FILL  | priming line buffers, first IMG_WIDTH+1 inputs, no output
    // RUN   | one output per accepted input, centre lags input by IMG_WIDTH+1
    // FLUSH | draining last IMG_WIDTH+1 (border) outputs, inputs dropped
    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMG_WIDTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, ocol_q, ocol_d;
    logic [RW-1:0]   row_q, row_d, orow_q, orow_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [7:0]      w1_top_q, w1_mid_q, w1_bot_q, w1_top_d, w1_mid_d, w1_bot_d;
    logic [7:0]      w2_top_q, w2_mid_q, w2_bot_q, w2_top_d, w2_mid_d, w2_bot_d;
    logic [1:0]      w1_dir_q, w1_dir_d;
    logic [7:0]      mag_q, mag_d;
    logic            valid_q, valid_d, done_q, done_d, ovr_q, ovr_d;

    // lb1 holds the previous row (mag+dir); lb2 the row before it (mag only: never a centre)
    logic [9:0]      lb1_mem [IMG_WIDTH];
    logic [7:0]      lb2_mem [IMG_WIDTH];
    logic [9:0]      lb1_rd;
    logic [7:0]      lb2_rd;
    logic            accept;

    logic [7:0]      nb_a, nb_b, nms_val;
    logic            interior;

    assign accept = pixel_in_valid && (state_q != S_FLUSH);
    assign lb1_rd = lb1_mem[col_q];
    assign lb2_rd = lb2_mem[col_q];

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb1_mem[col_q] <= {grad_dir, grad_mag};
            lb2_mem[col_q] <= lb1_rd[7:0];
        end
    end

    // Window columns: w2 = west, w1 = centre, incoming (lb2/lb1/input) = east
    always_comb begin
        nb_a = 8'd0;
        nb_b = 8'd0;
        case (w1_dir_q)
            2'b00:   begin nb_a = w2_mid_q; nb_b = lb1_rd[7:0]; end
            2'b10:   begin nb_a = w1_top_q; nb_b = w1_bot_q;    end
            2'b11:   begin nb_a = lb2_rd;   nb_b = w2_bot_q;    end
            default: begin nb_a = w2_top_q; nb_b = grad_mag;    end
        endcase
        interior = (ocol_q != '0) && (ocol_q != COL_LAST) &&
                   (orow_q != '0) && (orow_q != ROW_LAST);
        nms_val  = (interior && (w1_mid_q > nb_a) && (w1_mid_q >= nb_b)) ? w1_mid_q : 8'd0;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        ocol_d   = ocol_q;
        orow_d   = orow_q;
        fcnt_d   = fcnt_q;
        w1_top_d = w1_top_q;
        w1_mid_d = w1_mid_q;
        w1_bot_d = w1_bot_q;
        w1_dir_d = w1_dir_q;
        w2_top_d = w2_top_q;
        w2_mid_d = w2_mid_q;
        w2_bot_d = w2_bot_q;
        mag_d    = 8'd0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        ovr_d    = ovr_q | (pixel_in_valid && (state_q == S_FLUSH));

        if (accept) begin
            w2_top_d = w1_top_q;
            w2_mid_d = w1_mid_q;
            w2_bot_d = w1_bot_q;
            w1_top_d = lb2_rd;
            w1_mid_d = lb1_rd[7:0];
            w1_bot_d = grad_mag;
            w1_dir_d = lb1_rd[9:8];
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if ((state_q == S_RUN && pixel_in_valid) || state_q == S_FLUSH) begin
            valid_d = 1'b1;
            mag_d   = (state_q == S_RUN) ? nms_val : 8'd0;
            if (ocol_q == COL_LAST) begin
                ocol_d = '0;
                orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
            end else begin
                ocol_d = ocol_q + 1'b1;
            end
        end

        case (state_q)
            S_FILL: begin
                if (pixel_in_valid && row_q == RW'(1) && col_q == '0)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (pixel_in_valid && row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q - 1'b1;
                if (fcnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_FILL;
                    col_d   = '0;
                    row_d   = '0;
                    ocol_d  = '0;
                    orow_d  = '0;
                    fcnt_d  = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FILL;
            col_q    <= '0;
            row_q    <= '0;
            ocol_q   <= '0;
            orow_q   <= '0;
            fcnt_q   <= '0;
            w1_top_q <= '0;
            w1_mid_q <= '0;
            w1_bot_q <= '0;
            w1_dir_q <= '0;
            w2_top_q <= '0;
            w2_mid_q <= '0;
            w2_bot_q <= '0;
            mag_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ocol_q   <= ocol_d;
            orow_q   <= orow_d;
            fcnt_q   <= fcnt_d;
            w1_top_q <= w1_top_d;
            w1_mid_q <= w1_mid_d;
            w1_bot_q <= w1_bot_d;
            w1_dir_q <= w1_dir_d;
            w2_top_q <= w2_top_d;
            w2_mid_q <= w2_mid_d;
            w2_bot_q <= w2_bot_d;
            mag_q    <= mag_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign nms_mag     = mag_q;
    assign nms_valid   = valid_q;
    assign frame_done  = done_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_non_max_suppression.sv
// Bench for non_max_suppression on a 5x4 image: directed and random frames against a 2-D reference model.
// Each expected output carries its value, the cycle it must appear in and its frame_done flag.
module tb_non_max_suppression;
    localparam int W = 5;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] grad_mag;
    logic [1:0] grad_dir;
    logic       pixel_in_valid;
    logic [7:0] nms_mag;
    logic       nms_valid;
    logic       frame_done;
    logic       overrun_err;

    non_max_suppression #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .grad_mag       (grad_mag),
        .grad_dir       (grad_dir),
        .pixel_in_valid (pixel_in_valid),
        .nms_mag        (nms_mag),
        .nms_valid      (nms_valid),
        .frame_done     (frame_done),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mag;
        int cyc;
        bit done;
    } exp_t;
    exp_t expq[$];

    int fm[N];
    int fd[N];
    int em[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: centre survives if strictly above neighbour A and not below neighbour B
    function automatic void build_expect();
        for (int p = 0; p < N; p++) begin
            int r, c, ar, ac, br, bc, a, b;
            r = p / W;
            c = p % W;
            em[p] = 0;
            if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                case (fd[p])
                    0:       begin ar = 0;  ac = -1; br = 0; bc = 1;  end
                    2:       begin ar = -1; ac = 0;  br = 1; bc = 0;  end
                    3:       begin ar = -1; ac = 1;  br = 1; bc = -1; end
                    default: begin ar = -1; ac = -1; br = 1; bc = 1;  end
                endcase
                a = fm[(r + ar) * W + c + ac];
                b = fm[(r + br) * W + c + bc];
                if (fm[p] > a && fm[p] >= b) em[p] = fm[p];
            end
        end
    endfunction

    always @(negedge clk) begin
        if (nms_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("mag", nms_mag, e.mag);
                check("latency", cyc, e.cyc);
                check("frame_done", frame_done, e.done);
            end
        end else if (frame_done !== 1'b0) begin
            check("stray_done", frame_done, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_in_valid = 1'b0;
            grad_mag = 8'($urandom);
        end
    endtask

    task automatic send(input int k, output int t);
        @(negedge clk);
        grad_mag = 8'(fm[k]);
        grad_dir = 2'(fd[k]);
        pixel_in_valid = 1'b1;
        t = cyc;
        if (k >= W + 1) begin
            exp_t e;
            e.mag = em[k - W - 1];
            e.cyc = t + 1;
            e.done = 1'b0;
            expq.push_back(e);
        end
    endtask

    task automatic run_frame(input int gap_max, input int ovr);
        int t;
        build_expect();
        for (int k = 0; k < N; k++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send(k, t);
        end
        for (int j = 1; j <= W + 1; j++) begin
            exp_t e;
            e.mag = em[N - W - 2 + j];
            e.cyc = t + 1 + j;
            e.done = (j == W + 1);
            expq.push_back(e);
        end
        for (int j = 1; j <= W + 1; j++) begin
            @(negedge clk);
            pixel_in_valid = (j <= ovr);
            grad_mag = 8'($urandom);
            grad_dir = 2'($urandom);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        repeat (2) @(negedge clk);
        while (expq.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("drain", expq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void fill_random(input int maxv);
        for (int p = 0; p < N; p++) begin
            fm[p] = $urandom_range(0, maxv);
            fd[p] = $urandom_range(0, 3);
        end
    endfunction

    initial begin
        int t;
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        grad_mag = 8'd0;
        grad_dir = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_mag", nms_mag, 0);
        check("rst_valid", nms_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_overrun", overrun_err, 0);
        rst = 1'b0;

        // constant plateau: every tie suppressed
        for (int p = 0; p < N; p++) begin fm[p] = 50; fd[p] = 0; end
        run_frame(0, 0);
        drain();

        // single interior peak at (1,2)
        for (int p = 0; p < N; p++) begin fm[p] = 10; fd[p] = 0; end
        fm[7] = 200;
        run_frame(0, 0);
        drain();

        // horizontal ramp rows with an equal-valued pair in row 1
        for (int p = 0; p < N; p++) begin fm[p] = 10 * (p % W + 1); fd[p] = 0; end
        fm[5] = 40; fm[6] = 90; fm[7] = 90; fm[8] = 40; fm[9] = 10;
        run_frame(0, 0);
        drain();

        // each direction with the maximum at A, at B, then at the centre
        for (int d = 0; d < 4; d++) begin
            for (int pos = 0; pos < 3; pos++) begin
                for (int p = 0; p < N; p++) begin fm[p] = 20; fd[p] = d; end
                fm[7] = 100;
                case (d)
                    0: begin if (pos == 0) fm[6] = 150; if (pos == 1) fm[8] = 150; end
                    2: begin if (pos == 0) fm[2] = 150; if (pos == 1) fm[12] = 150; end
                    3: begin if (pos == 0) fm[3] = 150; if (pos == 1) fm[11] = 150; end
                    default: begin if (pos == 0) fm[1] = 150; if (pos == 1) fm[13] = 150; end
                endcase
                run_frame(0, 0);
                drain();
            end
        end

        fill_random(3);
        run_frame(2, 0);
        drain();
        for (int f = 0; f < 4; f++) begin
            fill_random(255);
            run_frame(3, 0);
        end
        drain();
        check("no_overrun", overrun_err, 0);

        fill_random(255);
        run_frame(1, 3);
        drain();
        check("overrun_set", overrun_err, 1);
        do_reset();
        check("overrun_cleared", overrun_err, 0);

        // abandon a frame after 9 inputs, then a clean frame
        fill_random(255);
        build_expect();
        for (int k = 0; k < 9; k++) send(k, t);
        do_reset();
        drain();
        fill_random(255);
        run_frame(1, 0);
        drain();
        check("overrun_after_abort", overrun_err, 0);

        for (int f = 0; f < 3; f++) begin
            fill_random(15);
            run_frame(0, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
